gemm_tile_sequencer: RTL

// - Parametrised successor to the fixed GEMM controller: sequences an output-stationary tiled GEMM
//   of runtime size MxK * KxN on a RowPar x ColPar MAC array.
// - Generates SRAM A/B read and C write addresses, and MAC valid/clear/last strobes.
// - Adds relocatable base addresses, selectable tile loop order, stall backpressure and a dimension error flag.

---
 rtl/gemm_pkg.sv | 16 +
 rtl/gemm_loop_counter.sv | 26 ++
 rtl/gemm_tile_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the tiled GEMM sequencer.
package gemm_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_e;

  typedef enum logic {ORDER_N_INNER = 1'b0, ORDER_M_INNER = 1'b1} loop_order_e;

  localparam int CalcWidth = 64;

  // Widened so num + den - 1 style overflow can never bite; callers truncate.
  function automatic logic [CalcWidth-1:0] ceil_div(input logic [CalcWidth-1:0] num,
                                                    input logic [CalcWidth-1:0] den);
    ceil_div = (num / den) + {{(CalcWidth-1){1'b0}}, ((num % den) != '0)};
  endfunction

endpackage

// File: rtl/gemm_loop_counter.sv
// Up-counter with a runtime limit; wraps to 0 and raises carry_o on the final enabled step.
module gemm_loop_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             carry_o
);

  assign carry_o = en_i && (count_o == limit_i - Width'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= carry_o ? '0 : count_o + Width'(1);
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Output-stationary tiled GEMM sequencer: walks k within a tile, then tiles in the
// selected loop order, emitting SRAM addresses and aligned MAC strobes.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int RowPar        = 4,
  parameter int ColPar        = 16,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     a_base_i,
  input  logic [AddrWidth-1:0]     b_base_i,
  input  logic [AddrWidth-1:0]     c_base_i,
  input  logic                     loop_order_i,
  input  logic                     stall_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_valid_o,
  output logic                     mac_clear_o,
  output logic                     mac_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  state_e                   state, state_next;
  logic [SizeAddrWidth-1:0] k_size, m_tiles, n_tiles;
  logic [AddrWidth-1:0]     a_base, b_base, c_base;
  loop_order_e              order;
  logic                     err;

  logic                     start_accept, issue, tile_step, m_inner, addr_live;
  logic [SizeAddrWidth-1:0] k_count, inner_count, outer_count;
  logic [SizeAddrWidth-1:0] inner_limit, outer_limit, rb, cb;
  logic                     k_carry, inner_carry, outer_carry;

  assign start_accept = (state == IDLE) && start_i;
  assign issue        = (state == FETCH) && !stall_i && !err;
  assign tile_step    = (state == WRITE) && !stall_i;
  assign m_inner      = (order == ORDER_M_INNER);
  assign inner_limit  = m_inner ? m_tiles : n_tiles;
  assign outer_limit  = m_inner ? n_tiles : m_tiles;
  assign rb           = m_inner ? inner_count : outer_count;
  assign cb           = m_inner ? outer_count : inner_count;

  // Error is decided from the raw sizes at start so the first FETCH cycle can bail straight to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_size  <= '0;
      m_tiles <= '0;
      n_tiles <= '0;
      a_base  <= '0;
      b_base  <= '0;
      c_base  <= '0;
      order   <= ORDER_N_INNER;
      err     <= 1'b0;
    end else if (start_accept) begin
      k_size  <= K_size_i;
      m_tiles <= SizeAddrWidth'(ceil_div(CalcWidth'(M_size_i), CalcWidth'(RowPar)));
      n_tiles <= SizeAddrWidth'(ceil_div(CalcWidth'(N_size_i), CalcWidth'(ColPar)));
      a_base  <= a_base_i;
      b_base  <= b_base_i;
      c_base  <= c_base_i;
      order   <= loop_order_e'(loop_order_i);
      err     <= (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    end
  end

  gemm_loop_counter #(.Width(SizeAddrWidth)) u_k_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (start_accept),
    .en_i    (issue),
    .limit_i (k_size),
    .count_o (k_count),
    .carry_o (k_carry)
  );

  gemm_loop_counter #(.Width(SizeAddrWidth)) u_inner_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (start_accept),
    .en_i    (tile_step),
    .limit_i (inner_limit),
    .count_o (inner_count),
    .carry_o (inner_carry)
  );

  // Outer carry fires only when both counters wrap together, i.e. on the final tile's write.
  gemm_loop_counter #(.Width(SizeAddrWidth)) u_outer_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (start_accept),
    .en_i    (inner_carry),
    .limit_i (outer_limit),
    .count_o (outer_count),
    .carry_o (outer_carry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = FETCH;
      FETCH:   if (err) state_next = DONE;
               else if (k_carry) state_next = DRAIN;
      DRAIN:   state_next = WRITE;
      WRITE:   if (!stall_i) state_next = outer_carry ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes lag the issue cycle by one to line up with the SRAM read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mac_valid_o <= 1'b0;
      mac_clear_o <= 1'b0;
      mac_last_o  <= 1'b0;
    end else begin
      mac_valid_o <= issue;
      mac_clear_o <= issue && (k_count == '0);
      mac_last_o  <= k_carry;
    end
  end

  assign addr_live     = (state == FETCH) || (state == DRAIN) || (state == WRITE);
  assign sram_a_addr_o = addr_live ? AddrWidth'(SizeAddrWidth'(a_base) + rb * k_size + k_count) : '0;
  assign sram_b_addr_o = addr_live ? AddrWidth'(SizeAddrWidth'(b_base) + cb * k_size + k_count) : '0;
  assign sram_c_addr_o = addr_live ? AddrWidth'(SizeAddrWidth'(c_base) + rb * n_tiles + cb) : '0;
  assign sram_c_we_o   = tile_step;
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign err_o         = err;

endmodule
